// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential multiplier.
// State encoding and iteration-counter width function.
package mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mult_seq_nbit_if.sv
// Start/done handshake bundle for mult_seq_nbit.
// Optional ovf signal exists only when MULT_OVF_EN is defined.
interface mult_seq_nbit_if #(parameter int N = 32);

    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;
`ifdef MULT_OVF_EN
    logic           ovf;
`endif

    modport master (
        output start, a, b,
`ifdef MULT_OVF_EN
        input  ovf,
`endif
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
`ifdef MULT_OVF_EN
        output ovf,
`endif
        output busy, done, product
    );

endinterface

// File: rtl/rca_Nbit.sv
// N-bit ripple-carry adder.
// Carry ripples LSB to MSB through one full adder per bit.
module rca_Nbit #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] S,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;
    assign cout = c[N];

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign S[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

endmodule

// File: rtl/mult_seq_nbit.sv
// Sequential unsigned shift-and-add multiplier, one add per clock.
// Define MULT_OVF_EN to add a registered ovf flag (HI != 0).
module mult_seq_nbit
    import mult_pkg::*;
#(
    parameter int N = 32
) (
    input logic           clk,
    input logic           rst,
    mult_seq_nbit_if.slave bus
);

    localparam int CW = cnt_w(N);

    state_t         state;
    state_t         state_nx;
    logic [N-1:0]   mcand;
    logic [N-1:0]   acc;
    logic [N-1:0]   mq;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   addend;
    logic [N-1:0]   sum;
    logic           c_out;
    logic           accept;
    logic           last;

    assign accept = bus.start &&
                    ((state == S_IDLE) || (state == S_DONE));
    assign last   = (state == S_RUN) && (cnt == CW'(N - 1));
    assign addend = mq[0] ? mcand : '0;

    rca_Nbit #(.N(N)) u_rca (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .S    (sum),
        .cout (c_out)
    );

    // State register; reset overrides any start on the same edge.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state: start accepted from IDLE or DONE, N iterations in RUN.
    always_comb begin
        state_nx = state;
        unique case (1'b1)
            state == S_IDLE: state_nx = bus.start ? S_RUN : S_IDLE;
            state == S_RUN:  state_nx = last ? S_DONE : S_RUN;
            state == S_DONE: state_nx = bus.start ? S_RUN : S_IDLE;
            default:         state_nx = S_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        bus.busy = (state == S_RUN);
        bus.done = (state == S_DONE);
    end

    // Datapath: capture operands, then shift {carry,sum,mq} right once per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
            mq    <= '0;
            cnt   <= '0;
        end else if (accept) begin
            mcand <= bus.a;
            acc   <= '0;
            mq    <= bus.b;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            acc   <= {c_out, sum[N-1:1]};
            mq    <= {sum[0], mq[N-1:1]};
            cnt   <= cnt + CW'(1);
        end
    end

    assign bus.product = {acc, mq};

`ifdef MULT_OVF_EN
    logic ovf_q;

    // Overflow flag: HI of the final product is nonzero, held until next start.
    always_ff @(posedge clk) begin
        if (rst)         ovf_q <= 1'b0;
        else if (accept) ovf_q <= 1'b0;
        else if (last)   ovf_q <= ({c_out, sum[N-1:1]} != '0);
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mult_seq_nbit.sv
// Scoreboard testbench for mult_seq_nbit (N=32).
// Stimulus pushes expected results; a negedge monitor pops and compares on done.
module tb_mult_seq_nbit;

    localparam int N = 32;

    typedef struct {
        logic [63:0] p;
        bit          o;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails = 0;
    int   ncyc = 0;
    exp_t sb[$];

    mult_seq_nbit_if #(.N(N)) bus ();

    mult_seq_nbit #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: count cycles, pop and compare on each done pulse.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        check("busy_done_excl", 64'(bus.busy & bus.done), 64'd0);
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("product", bus.product, e.p);
                check("done_cycle", 64'(ncyc), 64'(e.c));
`ifdef MULT_OVF_EN
                check("ovf", 64'(bus.ovf), 64'(e.o));
`endif
            end
        end
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] p, input bit o);
        bus.a = x;
        bus.b = y;
        bus.start = 1'b1;
        @(posedge clk);
        sb.push_back('{p, o, ncyc + N + 1});
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        for (int i = 0; i < 4 * N; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check({name, "_timeout"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_hold(input string name, input logic [63:0] p);
        @(negedge clk);
        check({name, "_hold_done"}, 64'(bus.done), 64'd0);
        check({name, "_hold_prod"}, bus.product, p);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_prod", bus.product, 64'd0);

        issue(32'd1, 32'd1, 64'h1, 1'b0);
        wait_drained("one");
        check_hold("one", 64'h1);

        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1);
        wait_drained("max");
        check_hold("max", 64'hFFFFFFFE_00000001);

        issue(32'd0, 32'h12345678, 64'h0, 1'b0);
        wait_drained("zero");

        issue(32'h0001_0000, 32'h0001_0000, 64'h1_00000000, 1'b1);
        wait_drained("pow");
        check_hold("pow", 64'h1_00000000);

        issue(32'd3, 32'd5, 64'd15, 1'b0);
        repeat (4) @(posedge clk);
        #1 bus.a = 32'd7;
        bus.b = 32'd7;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_drained("ignore");
        check_hold("ignore", 64'd15);

        bus.a = 32'd9;
        bus.b = 32'd9;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_prod", bus.product, 64'd0);
        repeat (40) @(negedge clk);
        issue(32'd6, 32'd7, 64'd42, 1'b0);
        wait_drained("after_rst");

        bus.a = 32'd2;
        bus.b = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        sb.push_back('{64'd6, 1'b0, ncyc + N + 1});
        #1 bus.a = 32'd4;
        bus.b = 32'd5;
        repeat (N) @(posedge clk);
        @(posedge clk);
        sb.push_back('{64'd20, 1'b0, ncyc + N + 1});
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("b2b_busy", 64'(bus.busy), 64'd1);
        wait_drained("b2b");
        check_hold("b2b", 64'd20);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
